// File: rtl/game_ctrl.sv
// Round controller for the register-matching game. It holds the IDLE/PLAY/WIN/LOSE
// state machine, the one-second tick divider, the target LFSR, and the BCD round and
// seconds counters that feed the display stage.
//
// Handshake: start and check_req are single-cycle pulses that have already been
// debounced. Each is sampled on the rising edge of clk. There is no ready/backpressure.
// start is acted on only in IDLE, and check_req only in PLAY. In any other state a
// pulse is dropped and nothing records it.
module game_ctrl #(
    parameter int         TICK_DIV   = 100000000,
    parameter logic [7:0] TIME_LIMIT = 8'h30,
    parameter int         HOLD_TICKS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        check_req,
    input  logic [63:0] data_string,
    output logic        s,
    output logic        game,
    output logic [15:0] count,
    output logic [15:0] target,
    output logic [1:0]  state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_LOSE = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [15:0]     target_q, target_d;
    logic [7:0]      sec_q, sec_d;
    logic [7:0]      round_q, round_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            s_q, s_d;
    logic            game_q, game_d;

    logic            tick;
    logic [63:0]     pattern;
    logic            match;
    logic            win_now;
    logic            fail_now;
    logic [6:0]      sec_bin;
    logic [6:0]      dec_amt;
    logic            lose_hit;
    logic [7:0]      sec_left;
    logic [7:0]      round_next;

    // Two packed BCD digits (00-99) converted to binary.
    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    // A binary value (0-99) converted to two packed BCD digits.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    assign tick    = (tick_cnt_q == TICK_LAST);
    // The player must enter the target rotated left by 0, 4, 8 and 12 bits, in reg1..reg4.
    assign pattern = {target_q[3:0], target_q[15:4],
                      target_q[7:0], target_q[15:8],
                      target_q[11:0], target_q[15:12],
                      target_q};
    assign match    = (data_string == pattern);
    assign win_now  = (state_q == ST_PLAY) && check_req && match;
    assign fail_now = (state_q == ST_PLAY) && check_req && !match;

    // A wrong guess costs 5 seconds. A tick in the same cycle adds 1 more.
    // The round is lost when the total cost reaches or passes the remaining time.
    assign sec_bin    = bcd_to_bin(sec_q);
    assign dec_amt    = (fail_now ? 7'd5 : 7'd0) + (tick ? 7'd1 : 7'd0);
    assign lose_hit   = (dec_amt != 7'd0) && (dec_amt >= sec_bin);
    assign sec_left   = bin_to_bcd(sec_bin - dec_amt);
    assign round_next = (round_q == 8'h99) ? 8'h01 : bin_to_bcd(bcd_to_bin(round_q) + 7'd1);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode. In PLAY a win takes priority over every loss condition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_PLAY;
            ST_PLAY: begin
                if (win_now) begin
                    state_d = ST_WIN;
                end else if (lose_hit) begin
                    state_d = ST_LOSE;
                end
            end
            ST_WIN, ST_LOSE: if (tick && (hold_q == HOLD_LAST)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so that the registered copies line up with state_q.
    always_comb begin
        s_d    = (state_d != ST_PLAY);
        game_d = (state_d == ST_PLAY);
    end

    // Datapath next values: tick divider, LFSR, target, seconds, round and hold counter.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        lfsr_d     = lfsr_q;
        target_d   = target_q;
        sec_d      = sec_q;
        round_d    = round_q;
        hold_d     = hold_q;
        case (state_q)
            ST_IDLE: begin
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                if (start) begin
                    tick_cnt_d = '0;
                    sec_d      = TIME_LIMIT;
                    target_d   = lfsr_q;
                end
            end
            ST_PLAY: begin
                if (win_now) begin
                    round_d = round_next;
                    hold_d  = '0;
                end else if (lose_hit) begin
                    sec_d   = 8'h00;
                    round_d = 8'h01;
                    hold_d  = '0;
                end else begin
                    sec_d = sec_left;
                end
            end
            default: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        sec_d  = 8'h00;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            lfsr_q     <= LFSR_SEED;
            target_q   <= 16'h0000;
            sec_q      <= 8'h00;
            round_q    <= 8'h01;
            hold_q     <= '0;
            s_q        <= 1'b1;
            game_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            lfsr_q     <= lfsr_d;
            target_q   <= target_d;
            sec_q      <= sec_d;
            round_q    <= round_d;
            hold_q     <= hold_d;
            s_q        <= s_d;
            game_q     <= game_d;
        end
    end

    assign s      = s_q;
    assign game   = game_q;
    assign count  = {round_q, sec_q};
    assign target = target_q;
    assign state  = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl. Its reference model works with integer seconds and rounds.
// Each scenario is a task that drives the inputs and checks the outputs itself.
module tb_game_ctrl;

    localparam int         TD     = 10;
    localparam logic [7:0] TL_BCD = 8'h05;
    localparam int         TL     = 5;
    localparam int         HT     = 3;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        start       = 1'b0;
    logic        check_req   = 1'b0;
    logic [63:0] data_string = '0;
    logic        s;
    logic        game;
    logic [15:0] count;
    logic [15:0] target;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    game_ctrl #(.TICK_DIV(TD), .TIME_LIMIT(TL_BCD), .HOLD_TICKS(HT)) u_dut (
        .clk(clk), .reset(reset), .start(start), .check_req(check_req),
        .data_string(data_string), .s(s), .game(game), .count(count),
        .target(target), .state(state)
    );

    // Clock block.
    always #5 clk = ~clk;

    // Reference model state. Phase 0=idle, 1=play, 2=win, 3=lose. Seconds and round are plain integers.
    int          m_phase = 0;
    int          m_sec   = 0;
    int          m_round = 1;
    int          m_tc    = 0;
    int          m_hold  = 0;
    int          m_dec   = 0;
    bit          m_tk    = 0;
    bit          m_hit   = 0;
    logic [15:0] m_target = 16'h0000;
    logic [15:0] m_lfsr   = 16'hACE1;

    function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [63:0] exp_pattern(input logic [15:0] t);
        return {rotl(t, 12), rotl(t, 8), rotl(t, 4), t};
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [35:0] exp_vec();
        return {2'(m_phase), 1'(m_phase != 1), 1'(m_phase == 1),
                to_bcd(m_round), to_bcd(m_sec), m_target};
    endfunction

    function automatic logic [35:0] dut_vec();
        return {state, s, game, count, target};
    endfunction

    // Game rules applied once per clock: seconds tick down, a wrong guess costs 5, a right guess wins.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_sec = 0; m_round = 1; m_tc = 0; m_hold = 0;
            m_target = 16'h0000; m_lfsr = 16'hACE1;
        end else begin
            m_tk  = (m_tc == TD - 1);
            m_hit = (data_string == exp_pattern(m_target));
            m_tc  = (m_phase == 0 && start) ? 0 : (m_tk ? 0 : m_tc + 1);
            case (m_phase)
                0: begin
                    if (start) begin
                        m_sec = TL; m_target = m_lfsr; m_phase = 1;
                    end
                    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                end
                1: begin
                    m_dec = (check_req ? 5 : 0) + (m_tk ? 1 : 0);
                    if (check_req && m_hit) begin
                        m_phase = 2; m_round = (m_round == 99) ? 1 : m_round + 1; m_hold = 0;
                    end else if (m_dec > 0) begin
                        if (m_sec <= m_dec) begin
                            m_sec = 0; m_phase = 3; m_round = 1; m_hold = 0;
                        end else begin
                            m_sec = m_sec - m_dec;
                        end
                    end
                end
                default: begin
                    if (m_tk) begin
                        if (m_hold == HT - 1) begin
                            m_phase = 0; m_sec = 0; m_hold = 0;
                        end else begin
                            m_hold++;
                        end
                    end
                end
            endcase
        end
    end

    // Driver: present the inputs for one clock, then return at the next falling edge.
    task automatic drive(input logic st, input logic ck, input logic [63:0] ds);
        start = st; check_req = ck; data_string = ds;
        @(negedge clk);
        start = 1'b0; check_req = 1'b0;
    endtask

    // Driver: idle the inputs until the state output equals want, or until the budget runs out.
    task automatic run_until(input logic [1:0] want, input int budget, output int used, output bit ok);
        used = 0; ok = 0;
        while (used < budget) begin
            drive(1'b0, 1'b0, 64'h0);
            used++;
            if (state === want) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%h exp=00", state); end
        checks++; if (s !== 1'b1) begin failures++; $display("FAIL reset_s got=%b exp=1", s); end
        checks++; if (game !== 1'b0) begin failures++; $display("FAIL reset_game got=%b exp=0", game); end
        checks++; if (count !== 16'h0100) begin failures++; $display("FAIL reset_count got=%h exp=0100", count); end
        checks++; if (target !== 16'h0000) begin failures++; $display("FAIL reset_target got=%h exp=0000", target); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start();
        repeat ($urandom_range(1, 20)) drive(1'b0, 1'b0, 64'h0);
        drive(1'b1, 1'b0, 64'h0);
        checks++; if (state !== 2'b01) begin failures++; $display("FAIL start_state got=%h exp=01", state); end
        checks++; if (count !== 16'h0105) begin failures++; $display("FAIL start_count got=%h exp=0105", count); end
        checks++; if ({s, game} !== 2'b01) begin failures++; $display("FAIL start_sgame got=%b exp=01", {s, game}); end
        checks++; if (target !== m_target) begin failures++; $display("FAIL start_target got=%h exp=%h", target, m_target); end
    endtask

    // Runs on from the round opened by test_start, with no player input.
    task automatic test_timeout();
        logic [7:0] secs[$];
        int         chg[$];
        logic [7:0] prev;
        logic [7:0] got;
        bit         lost;
        int         used;
        bit         ok;
        prev = count[7:0];
        secs.push_back(prev);
        lost = 0;
        for (int i = 1; i <= 20 * TD && !lost; i++) begin
            drive(1'b0, 1'b0, 64'h0);
            checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL timeout_cycle got=%h exp=%h", dut_vec(), exp_vec()); end
            if (count[7:0] !== prev) begin
                prev = count[7:0];
                secs.push_back(prev);
                chg.push_back(i);
            end
            if (state === 2'b11) lost = 1;
        end
        checks++; if (!lost) begin failures++; $display("FAIL timeout_lose got=%h exp=11", state); end
        for (int k = 0; k <= TL; k++) begin
            got = (k < secs.size()) ? secs[k] : 8'hxx;
            checks++; if (got !== to_bcd(TL - k)) begin failures++; $display("FAIL timeout_seq got=%h exp=%h", got, to_bcd(TL - k)); end
        end
        checks++; if (chg.size() != TL) begin failures++; $display("FAIL timeout_steps got=%0d exp=%0d", chg.size(), TL); end
        for (int k = 0; k < chg.size(); k++) begin
            checks++; if (chg[k] != (k + 1) * TD) begin failures++; $display("FAIL timeout_interval got=%0d exp=%0d", chg[k], (k + 1) * TD); end
        end
        run_until(2'b00, 5 * TD, used, ok);
        checks++; if (!ok || count !== 16'h0100) begin failures++; $display("FAIL timeout_return got=%h exp=0100", count); end
    endtask

    task automatic test_win();
        int used;
        bit ok;
        drive(1'b1, 1'b0, 64'h0);
        drive(1'b0, 1'b1, exp_pattern(m_target));
        checks++; if (state !== 2'b10) begin failures++; $display("FAIL win_state got=%h exp=10", state); end
        checks++; if (count !== {8'h02, TL_BCD}) begin failures++; $display("FAIL win_count got=%h exp=%h", count, {8'h02, TL_BCD}); end
        checks++; if ({s, game} !== 2'b10) begin failures++; $display("FAIL win_sgame got=%b exp=10", {s, game}); end
        run_until(2'b00, 5 * TD, used, ok);
        checks++; if (!ok || used != 3 * TD - 1) begin failures++; $display("FAIL win_hold got=%0d exp=%0d", used, 3 * TD - 1); end
        checks++; if (count !== 16'h0200) begin failures++; $display("FAIL win_idle_count got=%h exp=0200", count); end
    endtask

    task automatic test_fail();
        int used;
        bit ok;
        drive(1'b1, 1'b0, 64'h0);
        drive(1'b0, 1'b1, 64'h0);
        checks++; if (state !== 2'b11) begin failures++; $display("FAIL fail_state got=%h exp=11", state); end
        checks++; if (count !== 16'h0100) begin failures++; $display("FAIL fail_count got=%h exp=0100", count); end
        run_until(2'b00, 5 * TD, used, ok);
        checks++; if (!ok || used != 3 * TD - 1) begin failures++; $display("FAIL fail_hold got=%0d exp=%0d", used, 3 * TD - 1); end
        checks++; if (count !== 16'h0100) begin failures++; $display("FAIL fail_round got=%h exp=0100", count); end
    endtask

    // A check is submitted on the same cycle as a tick.
    task automatic test_collision();
        int used;
        bit ok;
        drive(1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 2 * TD && m_tc != TD - 1; i++) drive(1'b0, 1'b0, 64'h0);
        drive(1'b0, 1'b1, exp_pattern(m_target));
        checks++; if (state !== 2'b10) begin failures++; $display("FAIL coll_win_state got=%h exp=10", state); end
        checks++; if (count !== {8'h02, TL_BCD}) begin failures++; $display("FAIL coll_win_count got=%h exp=%h", count, {8'h02, TL_BCD}); end
        run_until(2'b00, 5 * TD, used, ok);
        checks++; if (!ok) begin failures++; $display("FAIL coll_win_idle got=%h exp=00", state); end
        drive(1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 2 * TD && m_tc != TD - 1; i++) drive(1'b0, 1'b0, 64'h0);
        drive(1'b0, 1'b1, 64'h0);
        checks++; if (state !== 2'b11) begin failures++; $display("FAIL coll_fail_state got=%h exp=11", state); end
        checks++; if (count !== 16'h0100) begin failures++; $display("FAIL coll_fail_count got=%h exp=0100", count); end
        run_until(2'b00, 5 * TD, used, ok);
        checks++; if (!ok) begin failures++; $display("FAIL coll_fail_idle got=%h exp=00", state); end
    endtask

    // Wins rounds back to back from round 1 until the round counter wraps past 99.
    task automatic test_round_wrap();
        int exp_r;
        int used;
        bit ok;
        exp_r = 1;
        for (int i = 0; i < 99; i++) begin
            drive(1'b1, 1'b0, 64'h0);
            drive(1'b0, 1'b1, exp_pattern(m_target));
            exp_r = (exp_r % 99) + 1;
            checks++; if (count[15:8] !== to_bcd(exp_r)) begin failures++; $display("FAIL wrap_round got=%h exp=%h", count[15:8], to_bcd(exp_r)); end
            run_until(2'b00, 5 * TD, used, ok);
            checks++; if (!ok) begin failures++; $display("FAIL wrap_idle got=%h exp=00", state); end
        end
        checks++; if (count[15:8] !== 8'h01) begin failures++; $display("FAIL wrap_final got=%h exp=01", count[15:8]); end
    endtask

    task automatic test_random();
        logic        st;
        logic        ck;
        logic [63:0] ds;
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(0, 5)) begin
                drive(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
                checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL rand_idle got=%h exp=%h", dut_vec(), exp_vec()); end
            end
            drive(1'b1, 1'b0, 64'h0);
            for (int c = 0; c < 40 * TD && m_phase != 0; c++) begin
                st = ($urandom_range(0, 3) == 0);
                ck = ($urandom_range(0, 11) == 0);
                ds = ($urandom_range(0, 1) == 1) ? exp_pattern(m_target) : {$urandom, $urandom};
                drive(st, ck, ds);
                checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL rand_cycle got=%h exp=%h", dut_vec(), exp_vec()); end
            end
            checks++; if (state !== 2'b00) begin failures++; $display("FAIL rand_end got=%h exp=00", state); end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 4 * TD && !(m_phase == 1 && m_sec == 3); i++) drive(1'b0, 1'b0, 64'h0);
        checks++; if (count[7:0] !== 8'h03) begin failures++; $display("FAIL rmid_pre got=%h exp=03", count[7:0]); end
        #2 reset = 1'b1;
        #1;
        checks++; if (state !== 2'b00) begin failures++; $display("FAIL rmid_state got=%h exp=00", state); end
        checks++; if ({s, game} !== 2'b10) begin failures++; $display("FAIL rmid_sgame got=%b exp=10", {s, game}); end
        checks++; if (count !== 16'h0100) begin failures++; $display("FAIL rmid_count got=%h exp=0100", count); end
        checks++; if (target !== 16'h0000) begin failures++; $display("FAIL rmid_target got=%h exp=0000", target); end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 64'h0);
        checks++; if (target !== 16'hACE1) begin failures++; $display("FAIL rmid_seed got=%h exp=ace1", target); end
        checks++; if (count !== 16'h0105) begin failures++; $display("FAIL rmid_restart got=%h exp=0105", count); end
    endtask

    // Sequence the scenarios, then print the report.
    initial begin
        test_reset();
        test_start();
        test_timeout();
        test_win();
        test_fail();
        test_collision();
        test_round_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Time limit on the whole run.
    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000000, meaning clk cycles per one-second tick.
REQ-002 Parameter TIME_LIMIT, default 8'h30, meaning BCD seconds per round (two BCD digits, 01-99).
REQ-003 Parameter HOLD_TICKS, default 3, meaning ticks spent in WIN/LOSE before returning to IDLE.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle (debounced) request to begin a round.
REQ-007 check_req  in  1  single-cycle (debounced) request to submit the player's registers.
REQ-008 data_string  in  64  four 16-bit player registers {reg4,reg3,reg2,reg1} from the register/display stage.
REQ-009 s  out  1  display select to the register/display stage (1 = show count, 0 = show player edit).
REQ-010 game  out  1  round-active flag to the seven-segment driver.
REQ-011 count  out  16  {round BCD[15:8], seconds-remaining BCD[7:0]} for the seven-segment display.
REQ-012 target  out  16  target word of the current round, driven to the LEDs.
REQ-013 state  out  2  FSM state code: IDLE=00, PLAY=01, WIN=10, LOSE=11.

Function
REQ-014 An internal tick counter SHALL produce a one-cycle tick every TICK_DIV clk cycles, and SHALL be cleared on the cycle start is accepted so the first second is full length.
REQ-015 A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL advance every clk cycle while in IDLE and hold otherwise; it SHALL never reach all-zero.
REQ-016 The match condition SHALL be data_string == {rotl(target,12), rotl(target,8), rotl(target,4), target}, where rotl is a 16-bit rotate-left.
REQ-017 In IDLE: s=1, game=0, count[7:0]=8'h00; start SHALL load seconds=TIME_LIMIT, capture target=LFSR, and enter PLAY on the next cycle.
REQ-018 In PLAY: s=0, game=1; each tick SHALL decrement the seconds register by 1 in BCD (e.g. 8'h10 -> 8'h09).
REQ-019 In PLAY, check_req with match SHALL enter WIN on the next cycle.
REQ-020 In PLAY, check_req without match SHALL subtract 5 BCD seconds, saturating at 8'h00.
REQ-021 In PLAY, a tick with seconds == 8'h01 or 8'h00, or a failed check that saturates to 8'h00, SHALL enter LOSE.
REQ-022 If check_req with match and tick occur in the same cycle, WIN SHALL take priority and seconds SHALL NOT decrement.
REQ-023 If check_req without match and tick occur in the same cycle, the total decrement SHALL be 6, saturating at 8'h00.
REQ-024 start SHALL be ignored in PLAY, WIN and LOSE; check_req SHALL be ignored outside PLAY.
REQ-025 On entry to WIN, round SHALL increment in BCD, with 8'h99 wrapping to 8'h01; on entry to LOSE, round SHALL be set to 8'h01.
REQ-026 In WIN and LOSE: s=1, game=0, seconds frozen; after HOLD_TICKS ticks the FSM SHALL return to IDLE.
REQ-027 target SHALL hold its captured value from start until the next accepted start.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 Reset SHALL force, asynchronously: state=IDLE, s=1, game=0, count=16'h0100, target=16'h0000, LFSR=16'hACE1, tick counter=0, hold counter=0.
REQ-030 Reset asserted mid-round SHALL abandon the round with no WIN/LOSE side effects; round SHALL return to 8'h01.

Verification (TICK_DIV=10, TIME_LIMIT=8'h05, HOLD_TICKS=3)
REQ-031 Reset, then start -> state=01, count=16'h0105, s=0, game=1, target equal to the LFSR value on the start cycle.
REQ-032 Start, drive data_string to the rotated target pattern, pulse check_req -> state=10 next cycle, count[15:8]=8'h02; after 3 ticks state=00.
REQ-033 Start, pulse check_req with data_string=0 -> count[7:0]=8'h00 and state=11, then round=8'h01 after the hold period.
REQ-034 Start with no input -> count[7:0] steps 05,04,03,02,01 at tick intervals, then state=11 on the next tick.
REQ-035 Apply a matching check_req on the same cycle as a tick -> state=10 and seconds unchanged; then force round to 8'h99 and win -> round=8'h01.
REQ-036 Assert reset mid-PLAY with seconds=8'h03 -> all outputs equal the REQ-029 values immediately, without waiting for a clk edge.
